// File: rtl/nes_pad_poller.sv
// Purpose: polls NUM_PADS serial NES/SNES pads over shared latch/clock lines and publishes per-pad button words.
// Latency: latch rises the cycle after IDLE sees poll_en; valid arrives (2*NUM_BITS+1)*CLK_DIV cycles later.
// Backpressure: none; valid/pressed are single-cycle strobes and buttons holds until the next frame completes.
module nes_pad_poller #(
    parameter int NUM_PADS  = 2,
    parameter int NUM_BITS  = 8,
    parameter int CLK_DIV   = 300,
    parameter int GAP_TICKS = 1000,
    parameter int INVERT    = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         poll_en,
    input  logic [NUM_PADS-1:0]          nes_data,
    output logic                         nes_latch,
    output logic                         nes_clk,
    output logic [NUM_PADS*NUM_BITS-1:0] buttons,
    output logic                         valid,
    output logic [NUM_PADS*NUM_BITS-1:0] pressed,
    output logic                         busy
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int BW = $clog2(NUM_BITS);
    // Phase counter covers both the 2-tick latch and the GAP_TICKS idle gap.
    localparam int PW = $clog2(GAP_TICKS + 2);

    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(NUM_BITS - 1);
    localparam logic [PW-1:0] GAP_LAST = PW'(GAP_TICKS - 1);
    localparam logic [PW-1:0] LATCH_LAST = PW'(1);
    localparam logic INV = (INVERT != 0);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        SAMPLE,
        PULSE,
        DONE,
        GAP
    } state_t;

    state_t state, nextState;

    logic [CW-1:0] divCnt;
    logic [PW-1:0] phaseCnt;
    logic [BW-1:0] bitIdx;
    logic          tickEnd;

    logic [NUM_PADS-1:0][NUM_BITS-1:0] shadow, shadowNext;

    assign tickEnd = (divCnt == DIV_LAST);

    // Next-state logic: protocol sequencing, advancing only on tick boundaries.
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:   if (poll_en) nextState = LATCH;
            LATCH:  if (tickEnd && phaseCnt == LATCH_LAST) nextState = SAMPLE;
            SAMPLE: if (tickEnd) nextState = (bitIdx == BIT_LAST) ? DONE : PULSE;
            PULSE:  if (tickEnd) nextState = SAMPLE;
            DONE:   nextState = GAP;
            GAP:    if (tickEnd && phaseCnt == GAP_LAST) nextState = poll_en ? LATCH : IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Capture of the current bit from every pad, merged into the shadow word.
    always_comb begin
        shadowNext = shadow;
        if (state == SAMPLE && tickEnd) begin
            for (int p = 0; p < NUM_PADS; p++) begin
                shadowNext[p][bitIdx] = nes_data[p] ^ INV;
            end
        end
    end

    // State register plus tick, phase and bit counters; counters restart on every state change.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            divCnt   <= '0;
            phaseCnt <= '0;
            bitIdx   <= '0;
            shadow   <= '0;
        end else begin
            state  <= nextState;
            shadow <= shadowNext;
            if (nextState != state || state == IDLE || state == DONE || tickEnd) begin
                divCnt <= '0;
            end else begin
                divCnt <= divCnt + CW'(1);
            end
            if (nextState != state) begin
                phaseCnt <= '0;
            end else if (tickEnd) begin
                phaseCnt <= phaseCnt + PW'(1);
            end
            if (state == LATCH) begin
                bitIdx <= '0;
            end else if (state == PULSE && tickEnd) begin
                bitIdx <= bitIdx + BW'(1);
            end
        end
    end

    // Registered outputs decoded from the next state so pad lines change cleanly with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            nes_latch <= 1'b0;
            nes_clk   <= 1'b1;
            busy      <= 1'b0;
            valid     <= 1'b0;
            buttons   <= '0;
            pressed   <= '0;
        end else begin
            nes_latch <= (nextState == LATCH);
            nes_clk   <= (nextState != PULSE);
            busy      <= (nextState != IDLE);
            valid     <= (nextState == DONE);
            if (nextState == DONE) begin
                buttons <= shadowNext;
                pressed <= shadowNext & ~buttons;
            end else begin
                pressed <= '0;
            end
        end
    end

endmodule

// File: tb/tb_nes_pad_poller.sv
module tb_nes_pad_poller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset   = 1'b1;
    logic pollEnA = 1'b0;
    logic pollEnB = 1'b0;

    logic [1:0]  dataA;
    logic        latchA, clkA, validA, busyA;
    logic [15:0] buttonsA, pressedA;
    logic [0:0]  dataB;
    logic        latchB, clkB, validB, busyB;
    logic [11:0] buttonsB, pressedB;

    nes_pad_poller #(.NUM_PADS(2), .NUM_BITS(8), .CLK_DIV(4), .GAP_TICKS(2), .INVERT(1)) dutA (
        .clk(clk), .reset(reset), .poll_en(pollEnA), .nes_data(dataA),
        .nes_latch(latchA), .nes_clk(clkA), .buttons(buttonsA), .valid(validA),
        .pressed(pressedA), .busy(busyA)
    );

    nes_pad_poller #(.NUM_PADS(1), .NUM_BITS(12), .CLK_DIV(4), .GAP_TICKS(2), .INVERT(1)) dutB (
        .clk(clk), .reset(reset), .poll_en(pollEnB), .nes_data(dataB),
        .nes_latch(latchB), .nes_clk(clkB), .buttons(buttonsB), .valid(validB),
        .pressed(pressedB), .busy(busyB)
    );

    // Pad models: active-low 4021 shift registers; load while latch high, shift on rising clock.
    logic [7:0]  padA [2];
    logic [7:0]  srA  [2];
    logic [11:0] padB = '0;
    logic [11:0] srB  = '0;
    logic        pcA = 1'b1, pcB = 1'b1;

    initial begin
        padA[0] = '0; padA[1] = '0; srA[0] = '0; srA[1] = '0;
    end

    assign dataA = {~srA[1][0], ~srA[0][0]};
    assign dataB = ~srB[0];

    always @(negedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (latchA) srA[p] <= padA[p];
            else if (clkA && !pcA) srA[p] <= srA[p] >> 1;
        end
        if (latchB) srB <= padB;
        else if (clkB && !pcB) srB <= srB >> 1;
        pcA <= clkA;
        pcB <= clkB;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Observed frame statistics, all gathered in the main process.
    int cyc = 0, frameCyc = 0, latchCnt = 0, lowCyc = 0, pulses = 0;
    int validCnt = 0, validAt = -1, riseCnt = 0, lastRise = 0, period = 0;
    int frameCycB = 0, pulsesB = 0, validAtB = -1;
    logic prevLatchA = 1'b0, prevClkA = 1'b1, prevLatchB = 1'b0, prevClkB = 1'b1;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (latchA && !prevLatchA) begin
            frameCyc = 0; riseCnt++; period = cyc - lastRise; lastRise = cyc;
        end else frameCyc++;
        if (latchA) latchCnt++;
        if (!clkA) lowCyc++;
        if (!clkA && prevClkA) pulses++;
        if (validA) begin validCnt++; validAt = frameCyc; end
        if (latchB && !prevLatchB) frameCycB = 0; else frameCycB++;
        if (!clkB && prevClkB) pulsesB++;
        if (validB) validAtB = frameCycB;
        prevLatchA = latchA; prevClkA = clkA; prevLatchB = latchB; prevClkB = clkB;
    endtask

    task automatic clearStats();
        latchCnt = 0; lowCyc = 0; pulses = 0; validCnt = 0; validAt = -1;
        pulsesB = 0; validAtB = -1;
    endtask

    // Waits for one frame of dutA and checks its timing and published words.
    task automatic runFrameA(input logic [15:0] expB, input logic [15:0] expP, input string tag);
        int n = 0;
        while (!validA && n < 400) begin step(); n++; end
        chk({tag, " valid seen"}, 32'(validA), 32'd1);
        chk({tag, " valid cycle"}, validAt, 68);
        chk({tag, " latch cycles"}, latchCnt, 8);
        chk({tag, " clk pulses"}, pulses, 7);
        chk({tag, " clk low cycles"}, lowCyc, 28);
        chk({tag, " buttons"}, 32'(buttonsA), 32'(expB));
        chk({tag, " pressed"}, 32'(pressedA), 32'(expP));
        step();
        chk({tag, " valid drops"}, 32'(validA), 32'd0);
        chk({tag, " pressed clears"}, 32'(pressedA), 32'd0);
        chk({tag, " buttons hold"}, 32'(buttonsA), 32'(expB));
        chk({tag, " single valid"}, validCnt, 1);
        clearStats();
    endtask

    logic [15:0] prevExp, newExp;
    logic [11:0] randB;
    int r0, n;

    initial begin
        // Reset state and idle hold.
        repeat (3) step();
        chk("rst latch", 32'(latchA), 32'd0);
        chk("rst clk", 32'(clkA), 32'd1);
        chk("rst buttons", 32'(buttonsA), 32'd0);
        chk("rst valid", 32'(validA), 32'd0);
        chk("rst pressed", 32'(pressedA), 32'd0);
        chk("rst busy", 32'(busyA), 32'd0);
        reset = 1'b0;
        repeat (20) step();
        chk("idle busy", 32'(busyA), 32'd0);
        chk("idle no latch", riseCnt, 0);

        // First frame: pad0 A+Start.
        padA[0] = 8'h09; padA[1] = 8'h00;
        clearStats();
        pollEnA = 1'b1;
        runFrameA(16'h0009, 16'h0009, "frame1");

        // Second frame adds B on pad0 and Right on pad1; third frame is identical.
        padA[0] = 8'h0B; padA[1] = 8'h80;
        runFrameA(16'h800B, 16'h8002, "frame2");
        chk("frame period", period, 77);
        runFrameA(16'h800B, 16'h0000, "frame3");

        // Random frames against the new-and-not-old model.
        prevExp = 16'h800B;
        repeat (6) begin
            padA[0] = 8'($urandom); padA[1] = 8'($urandom);
            newExp = {padA[1], padA[0]};
            runFrameA(newExp, newExp & ~prevExp, "random");
            prevExp = newExp;
        end

        // Reset in the middle of a frame.
        r0 = riseCnt; n = 0;
        while (!(riseCnt > r0 && frameCyc == 30) && n < 200) begin step(); n++; end
        chk("reach cycle 30", frameCyc, 30);
        reset = 1'b1; pollEnA = 1'b0;
        step();
        chk("midrst latch", 32'(latchA), 32'd0);
        chk("midrst clk", 32'(clkA), 32'd1);
        chk("midrst buttons", 32'(buttonsA), 32'd0);
        chk("midrst valid", 32'(validA), 32'd0);
        chk("midrst pressed", 32'(pressedA), 32'd0);
        chk("midrst busy", 32'(busyA), 32'd0);
        reset = 1'b0;
        clearStats();
        repeat (100) step();
        chk("midrst no valid", validCnt, 0);
        chk("midrst stays idle", 32'(busyA), 32'd0);

        // Drop poll_en mid-frame: the frame still completes, then the poller idles.
        padA[0] = 8'h34; padA[1] = 8'h12;
        pollEnA = 1'b1;
        r0 = riseCnt; n = 0;
        while (!(riseCnt > r0 && frameCyc == 10) && n < 200) begin step(); n++; end
        chk("reach cycle 10", frameCyc, 10);
        pollEnA = 1'b0;
        runFrameA(16'h1234, 16'h1234, "pollstop");
        r0 = riseCnt;
        repeat (100) step();
        chk("pollstop no latch", riseCnt - r0, 0);
        chk("pollstop idle", 32'(busyA), 32'd0);

        // Twelve-bit single pad.
        padB = 12'hA5C;
        clearStats();
        pollEnB = 1'b1;
        n = 0;
        while (!validB && n < 400) begin step(); n++; end
        chk("snes valid seen", 32'(validB), 32'd1);
        chk("snes valid cycle", validAtB, 100);
        chk("snes clk pulses", pulsesB, 11);
        chk("snes buttons", 32'(buttonsB), 32'h0A5C);
        chk("snes pressed", 32'(pressedB), 32'h0A5C);
        step();
        randB = 12'($urandom);
        padB = randB;
        clearStats();
        n = 0;
        while (!validB && n < 400) begin step(); n++; end
        chk("snes rand valid cycle", validAtB, 100);
        chk("snes rand buttons", 32'(buttonsB), 32'(randB));
        chk("snes rand pressed", 32'(pressedB), 32'(randB & ~12'hA5C));
        pollEnB = 1'b0;
        repeat (60) step();
        chk("snes idle", 32'(busyB), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
